// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative WIDTH x WIDTH multiply / divide unit. It uses radix-2
//            shift-add multiply and restoring divide, signed or unsigned. Its
//            2*WIDTH result feeds the ALU result select stage, and the result
//            is held until the next accepted start.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-high reset
//            start        - request, sampled only while idle
//            op           - 00 MULU, 01 MUL, 10 DIVU, 11 DIV
//            a, b         - multiplicand/dividend, multiplier/divisor
//            result       - product, or {remainder, quotient}
//            busy         - operation in flight
//            done         - one-cycle pulse when result updates
//            div_by_zero  - divide with b==0, held until next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               zdiv_q, zdiv_d;       // divide by zero pending for FIX
  logic               neg_q, neg_d;         // negate product / quotient
  logic               neg_rem_q, neg_rem_d; // negate remainder (sign of a)
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;     // unmodified dividend for /0 result
  logic [WIDTH-1:0]   mag_q, mag_d;         // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand conditioning at the accepting edge
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Multiply step: conditional add into the upper half, with the carry
  // kept as bit 2*WIDTH-1 after the right shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  // Divide step: shift {rem, quo} left, then trial-subtract the divisor.
  logic [2*WIDTH:0]   div_shl;
  logic [WIDTH:0]     rem_try;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;

  // Sign fix-up
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sign_a = op[0] & a[WIDTH-1];
    sign_b = op[0] & b[WIDTH-1];
    abs_a  = sign_a ? (~a + 1'b1) : a;
    abs_b  = sign_b ? (~b + 1'b1) : b;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_shl  = {acc_q, 1'b0};
    rem_try  = div_shl[2*WIDTH:WIDTH];
    rem_ge   = (rem_try >= {1'b0, mag_q});
    rem_sub  = rem_try - {1'b0, mag_q};
    div_next = rem_ge ? {rem_sub[WIDTH-1:0], div_shl[WIDTH-1:1], 1'b1}
                      : div_shl[2*WIDTH-1:0];

    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                         : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    zdiv_d    = zdiv_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    raw_a_d   = raw_a_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          zdiv_d    = op[1] && (b == {WIDTH{1'b0}});
          raw_a_d   = a;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          busy_d    = 1'b1;
          dbz_d     = 1'b0;
          cnt_d     = C_LAST;
          if (op[1]) begin
            mag_d = abs_b;
            acc_d = {{WIDTH{1'b0}}, abs_a};
          end else begin
            mag_d = abs_a;
            acc_d = {{WIDTH{1'b0}}, abs_b};
          end
          // A zero divisor needs no iterations; FIX produces the fixed result.
          state_d = (op[1] && (b == {WIDTH{1'b0}})) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (zdiv_q) begin
          result_d = {raw_a_q, {WIDTH{1'b1}}};
          dbz_d    = 1'b1;
        end else if (is_div_q) begin
          result_d = {rem_fix, quo_fix};
        end else begin
          result_d = prod_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      is_div_q  <= 1'b0;
      zdiv_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      raw_a_q   <= {WIDTH{1'b0}};
      mag_q     <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      result_q  <= {(2*WIDTH){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      zdiv_q    <= zdiv_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      raw_a_q   <= raw_a_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
